// File: rtl/graphite_cmd_master.sv
// CPU command FIFO feeding the Graphite rasterizer
// over an AXI-stream master port (cmd_axis).
module graphite_cmd_master #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        wr_en_i,
  input  logic [1:0]  address_in_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        cmd_axis_tvalid_o,
  input  logic        cmd_axis_tready_i,
  output logic [31:0] cmd_axis_tdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          en_q;
  logic          tvalid_q;
  logic [31:0]   tdata_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic wr_cyc;
  logic rd_cyc;
  logic push_req;
  logic stat_wr;
  logic ctrl_wr;
  logic flush;
  logic full;
  logic idle;
  logic pop;
  logic push_ok;

  assign wr_cyc   = sel_i & wr_en_i;
  assign rd_cyc   = sel_i & ~wr_en_i;
  assign push_req = wr_cyc & (address_in_i == A_DATA);
  assign stat_wr  = wr_cyc & (address_in_i == A_STAT);
  assign ctrl_wr  = wr_cyc & (address_in_i == A_CTRL);
  assign flush    = ctrl_wr & data_in_i[1];

  assign full = (count_q == FULLC);
  assign idle = (count_q == '0) & ~tvalid_q;

  // A pop moves the FIFO head into the output
  // register; a flush write blocks it so nothing
  // from the discarded contents leaks out.
  assign pop = (count_q != '0) & en_q & ~flush
             & (~tvalid_q | cmd_axis_tready_i);

  // A push into a full FIFO still fits when the
  // head leaves in the same cycle.
  assign push_ok = push_req & (~full | pop);

  // Next occupancy from push/pop/flush
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_ok & ~pop) begin
      count_d = count_q + 1'b1;
    end else if (pop & ~push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Register read mux
  always_comb begin
    rdata_d = '0;
    unique case (address_in_i)
      A_STAT: rdata_d = {16'(count_q), 12'd0,
                         tvalid_q, ovf_q, full, idle};
      A_CTRL: rdata_d = {31'd0, en_q};
      default: rdata_d = '0;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= data_in_i;
    end
  end

  // Pointers, occupancy, control and status
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (flush) begin
        rptr_q <= wptr_q;
      end else if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (stat_wr & data_in_i[2]) begin
        ovf_q <= 1'b0;
      end else if (push_req & ~push_ok) begin
        ovf_q <= 1'b1;
      end
      if (ctrl_wr) begin
        en_q <= data_in_i[0];
      end
    end
  end

  // Stream output register; data holds while
  // the word waits for its handshake.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else if (pop) begin
      tvalid_q <= 1'b1;
      tdata_q  <= mem[rptr_q];
    end else if (cmd_axis_tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  // Read data captured on the sampling edge
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (rd_cyc) begin
      rdata_q <= rdata_d;
    end
  end

  assign data_out_o        = rdata_q;
  assign cmd_axis_tvalid_o = tvalid_q;
  assign cmd_axis_tdata_o  = tdata_q;

endmodule

// File: tb/tb_graphite_cmd_master.sv
// Scoreboard bench for graphite_cmd_master:
// directed bus traffic, stream words checked in order.
module tb_graphite_cmd_master;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        sel_i;
  logic        wr_en_i;
  logic [1:0]  address_in_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  graphite_cmd_master #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .sel_i             (sel_i),
    .wr_en_i           (wr_en_i),
    .address_in_i      (address_in_i),
    .data_in_i         (data_in_i),
    .data_out_o        (data_out_o),
    .cmd_axis_tvalid_o (tvalid),
    .cmd_axis_tready_i (tready),
    .cmd_axis_tdata_o  (tdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a,
                        input logic [31:0] d);
    sel_i = 1'b1;
    wr_en_i = 1'b1;
    address_in_i = a;
    data_in_i = d;
    step();
    sel_i = 1'b0;
    wr_en_i = 1'b0;
  endtask

  task automatic bus_rd(input string nm,
                        input logic [1:0] a,
                        input logic [31:0] exp);
    sel_i = 1'b1;
    wr_en_i = 1'b0;
    address_in_i = a;
    step();
    sel_i = 1'b0;
    chk(nm, data_out_o, exp);
  endtask

  task automatic push(input logic [31:0] d,
                      input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    bus_wr(2'd0, d);
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !tvalid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: got %0d words left want 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: in-order stream compare plus AXI hold rule
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    if (reset_i) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, tvalid}, 32'd1);
        chk("hold_data", tdata, pd);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %h want none",
                   tdata);
        end else begin
          chk("stream", tdata, exp_q.pop_front());
        end
      end
      pv = tvalid;
      pr = tready;
      pd = tdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    sel_i = 1'b0;
    wr_en_i = 1'b0;
    address_in_i = 2'd0;
    data_in_i = '0;
    tready = 1'b0;
    repeat (2) step();
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_dout", data_out_o, 32'd0);
    reset_i = 1'b0;
    step();

    // registers after reset
    bus_rd("rst_status", 2'd1, 32'h1);
    bus_rd("rst_ctrl", 2'd2, 32'h1);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd("rsvd_rd", 2'd3, 32'h0);
    bus_rd("data_rd", 2'd0, 32'h0);
    bus_wr(2'd2, 32'hFFFF_FFFD);
    bus_rd("ctrl_bits", 2'd2, 32'h1);

    // basic stream with 2-cycle latency
    tready = 1'b1;
    push(32'h11, 1'b1);
    chk("lat_edge_n", {31'd0, tvalid}, 32'd0);
    push(32'h22, 1'b1);
    chk("lat_edge_n1", {31'd0, tvalid}, 32'd1);
    chk("lat_data", tdata, 32'h11);
    push(32'h33, 1'b1);
    drain("drain_basic");
    bus_rd("idle_status", 2'd1, 32'h1);

    // backpressure fill and overflow
    tready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(32'h100 + i, i <= DEPTH);
    end
    bus_rd("ovf_status", 2'd1,
           (32'(DEPTH) << 16) | 32'hE);
    tready = 1'b1;
    drain("drain_ovf");
    bus_wr(2'd1, 32'h4);
    bus_rd("ovf_clear", 2'd1, 32'h1);

    // enable gating
    tready = 1'b0;
    push(32'hA1, 1'b1);
    push(32'hA2, 1'b1);
    push(32'hA3, 1'b1);
    bus_wr(2'd2, 32'h0);
    repeat (2) step();
    chk("dis_valid", {31'd0, tvalid}, 32'd1);
    chk("dis_data", tdata, 32'hA1);
    tready = 1'b1;
    step();
    tready = 1'b0;
    chk("dis_drop", {31'd0, tvalid}, 32'd0);
    bus_rd("dis_status", 2'd1, 32'h0002_0000);
    tready = 1'b1;
    bus_wr(2'd2, 32'h1);
    chk("en_wait", {31'd0, tvalid}, 32'd0);
    step();
    chk("en_valid", {31'd0, tvalid}, 32'd1);
    chk("en_data", tdata, 32'hA2);
    drain("drain_en");

    // flush keeps the presented word
    tready = 1'b0;
    push(32'hA, 1'b1);
    push(32'hB, 1'b0);
    push(32'hC, 1'b0);
    bus_wr(2'd2, 32'h3);
    bus_rd("flush_status", 2'd1, 32'h8);
    chk("flush_data", tdata, 32'hA);
    tready = 1'b1;
    drain("drain_flush");
    repeat (3) step();
    bus_rd("flush_after", 2'd1, 32'h1);

    // full FIFO push alongside pop, pointer wrap
    tready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      push(32'h500 + i, 1'b1);
    end
    tready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      push(32'h600 + i, 1'b1);
    end
    bus_rd("full_pp_status", 2'd1,
           (32'(DEPTH) << 16) | 32'hA);
    drain("drain_wrap");

    // asynchronous reset mid-burst
    tready = 1'b0;
    push(32'h71, 1'b0);
    push(32'h72, 1'b0);
    push(32'h73, 1'b0);
    @(posedge clk);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_tvalid", {31'd0, tvalid}, 32'd0);
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    step();
    bus_rd("post_rst_status", 2'd1, 32'h1);
    tready = 1'b1;
    push(32'h77, 1'b1);
    chk("post_lat_n", {31'd0, tvalid}, 32'd0);
    step();
    chk("post_lat_n1", {31'd0, tvalid}, 32'd1);
    chk("post_data", tdata, 32'h77);
    drain("drain_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
